// File: rtl/braille_stream_ctrl_pkg.sv
// Shared types and ASCII classification for the Braille stream controller.
// The controller FSM and the ASCII-to-Braille lookup both use this classification.
package braille_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_PFX   = 3'd1,
    ST_CHAR  = 3'd2,
    ST_DWELL = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    CLS_BAD   = 3'd0,
    CLS_SPACE = 3'd1,
    CLS_PUNCT = 3'd2,
    CLS_DIGIT = 3'd3,
    CLS_UPPER = 3'd4,
    CLS_LOWER = 3'd5
  } char_class_t;

  localparam logic [7:0] CAP_CELL_DEF = 8'b0010_0000;
  localparam logic [7:0] NUM_CELL_DEF = 8'b0011_1100;

  localparam logic [6:0] ASC_NUL    = 7'h00;
  localparam logic [6:0] ASC_SPACE  = 7'h20;
  localparam logic [6:0] ASC_EXCL   = 7'h21;
  localparam logic [6:0] ASC_COMMA  = 7'h2C;
  localparam logic [6:0] ASC_PERIOD = 7'h2E;
  localparam logic [6:0] ASC_COLON  = 7'h3A;
  localparam logic [6:0] ASC_QUEST  = 7'h3F;
  localparam logic [6:0] ASC_DIG_LO = 7'h30;
  localparam logic [6:0] ASC_DIG_HI = 7'h39;
  localparam logic [6:0] ASC_UP_LO  = 7'h41;
  localparam logic [6:0] ASC_UP_HI  = 7'h5A;
  localparam logic [6:0] ASC_LO_LO  = 7'h61;
  localparam logic [6:0] ASC_LO_HI  = 7'h7A;

  function automatic char_class_t classify(input logic [6:0] c);
    if (c == ASC_NUL || c == ASC_SPACE)                   return CLS_SPACE;
    if (c == ASC_EXCL || c == ASC_COMMA || c == ASC_PERIOD ||
        c == ASC_COLON || c == ASC_QUEST)                 return CLS_PUNCT;
    if (c >= ASC_DIG_LO && c <= ASC_DIG_HI)               return CLS_DIGIT;
    if (c >= ASC_UP_LO && c <= ASC_UP_HI)                 return CLS_UPPER;
    if (c >= ASC_LO_LO && c <= ASC_LO_HI)                 return CLS_LOWER;
    return CLS_BAD;
  endfunction

endpackage

// File: rtl/braille_stream_ctrl_if.sv
// Host character stream (valid/ready) plus actuator cell stream (valid/ready) and status.
// A transfer happens on a rising clk edge where valid and ready are both high; valid never drops without one.
interface braille_stream_ctrl_if;
  logic                  in_valid;
  logic [6:0]            in_char;
  logic                  in_ready;
  logic                  cell_valid;
  logic [7:0]            cell_data;
  logic                  cell_ready;
  logic                  cell_is_prefix;
  logic                  busy;
  logic                  err_pulse;
  logic [7:0]            err_count;
  braille_pkg::state_t   dbg_state;

  modport slave (
    input  in_valid, in_char, cell_ready,
    output in_ready, cell_valid, cell_data, cell_is_prefix, busy, err_pulse, err_count, dbg_state
  );

  modport master (
    output in_valid, in_char, cell_ready,
    input  in_ready, cell_valid, cell_data, cell_is_prefix, busy, err_pulse, err_count, dbg_state
  );
endinterface

// File: rtl/braille_stream_ctrl_ascii2braile.sv
// Combinational ASCII-to-Braille lookup: bit k = dot k+1, bit 7 always 0.
// Digits reuse letters a-j ('1'=a ... '9'=i, '0'=j); upper and lower case share a cell.
module ascii2Braile
  import braille_pkg::*;
(
  input  logic [6:0] i_ascii,
  output logic [7:0] o_cell
);

  function automatic logic [7:0] letter_cell(input logic [4:0] idx);
    case (idx)
      5'd0:  return 8'h01;  5'd1:  return 8'h03;  5'd2:  return 8'h09;
      5'd3:  return 8'h19;  5'd4:  return 8'h11;  5'd5:  return 8'h0B;
      5'd6:  return 8'h1B;  5'd7:  return 8'h13;  5'd8:  return 8'h0A;
      5'd9:  return 8'h1A;  5'd10: return 8'h05;  5'd11: return 8'h07;
      5'd12: return 8'h0D;  5'd13: return 8'h1D;  5'd14: return 8'h15;
      5'd15: return 8'h0F;  5'd16: return 8'h1F;  5'd17: return 8'h17;
      5'd18: return 8'h0E;  5'd19: return 8'h1E;  5'd20: return 8'h25;
      5'd21: return 8'h27;  5'd22: return 8'h3A;  5'd23: return 8'h2D;
      5'd24: return 8'h3D;  5'd25: return 8'h35;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    o_cell = 8'h00;
    case (classify(i_ascii))
      CLS_UPPER: o_cell = letter_cell(5'(i_ascii - ASC_UP_LO));
      CLS_LOWER: o_cell = letter_cell(5'(i_ascii - ASC_LO_LO));
      CLS_DIGIT: o_cell = letter_cell((i_ascii == ASC_DIG_LO) ? 5'd9 : 5'(i_ascii - 7'h31));
      CLS_PUNCT: begin
        case (i_ascii)
          ASC_EXCL:   o_cell = 8'h16;
          ASC_COMMA:  o_cell = 8'h02;
          ASC_PERIOD: o_cell = 8'h32;
          ASC_COLON:  o_cell = 8'h12;
          ASC_QUEST:  o_cell = 8'h26;
          default:    o_cell = 8'h00;
        endcase
      end
      default:   o_cell = 8'h00;
    endcase
  end

endmodule

// File: rtl/braille_stream_ctrl.sv
// Sequences host characters into Braille cells with capital/number prefixes,
// a post-cell actuator dwell, and rejection counting for unsupported characters.
module braille_stream_ctrl
  import braille_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 4,
  parameter logic [7:0]  CAP_CELL     = CAP_CELL_DEF,
  parameter logic [7:0]  NUM_CELL     = NUM_CELL_DEF
) (
  input  logic clk,
  input  logic rst_n,
  braille_stream_ctrl_if.slave bus
);

  localparam int unsigned CW        = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = (DWELL_CYCLES == 0) ? '0 : CW'(DWELL_CYCLES - 1);
  localparam bit HAS_DWELL = (DWELL_CYCLES != 0);

  state_t        r_state;
  logic          r_num_mode;
  logic [6:0]    r_char;
  logic [CW-1:0] r_dwell_cnt;
  logic          r_ret_char;
  logic          r_in_ready;
  logic          r_cell_valid;
  logic [7:0]    r_cell_data;
  logic          r_is_prefix;
  logic          r_busy;
  logic          r_err_pulse;
  logic [7:0]    r_err_count;

  logic [6:0]    w_lookup_in;
  logic [7:0]    w_lookup_cell;
  logic [7:0]    w_char_cell;
  char_class_t   w_cls;

  // In IDLE the lookup sees the incoming character so a direct IDLE->CHAR
  // transition can register its cell on the accept edge; elsewhere it sees r_char.
  assign w_lookup_in = (r_state == ST_IDLE) ? bus.in_char : r_char;
  assign w_cls       = classify(w_lookup_in);
  assign w_char_cell = (w_cls == CLS_SPACE) ? 8'h00 : w_lookup_cell;

  ascii2Braile u_lookup (
    .i_ascii (w_lookup_in),
    .o_cell  (w_lookup_cell)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_num_mode   <= 1'b0;
      r_char       <= '0;
      r_dwell_cnt  <= '0;
      r_ret_char   <= 1'b0;
      r_in_ready   <= 1'b0;
      r_cell_valid <= 1'b0;
      r_cell_data  <= '0;
      r_is_prefix  <= 1'b0;
      r_busy       <= 1'b0;
      r_err_pulse  <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_err_pulse <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_in_ready <= 1'b1;
          if (r_in_ready && bus.in_valid) begin
            r_char     <= bus.in_char;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b1;
            if (w_cls == CLS_BAD) begin
              r_state     <= ST_ERR;
              r_err_pulse <= 1'b1;
              if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
            end else if (w_cls == CLS_UPPER || (w_cls == CLS_DIGIT && !r_num_mode)) begin
              r_state      <= ST_PFX;
              r_cell_valid <= 1'b1;
              r_cell_data  <= (w_cls == CLS_UPPER) ? CAP_CELL : NUM_CELL;
              r_is_prefix  <= 1'b1;
            end else begin
              r_state      <= ST_CHAR;
              r_cell_valid <= 1'b1;
              r_cell_data  <= w_char_cell;
              r_is_prefix  <= 1'b0;
            end
          end
        end
        ST_PFX: begin
          if (bus.cell_ready) begin
            if (HAS_DWELL) begin
              r_state      <= ST_DWELL;
              r_cell_valid <= 1'b0;
              r_dwell_cnt  <= DWELL_LOAD;
              r_ret_char   <= 1'b1;
            end else begin
              r_state      <= ST_CHAR;
              r_cell_data  <= w_char_cell;
              r_is_prefix  <= 1'b0;
            end
          end
        end
        ST_CHAR: begin
          if (bus.cell_ready) begin
            r_num_mode   <= (w_cls == CLS_DIGIT);
            r_cell_valid <= 1'b0;
            if (HAS_DWELL) begin
              r_state     <= ST_DWELL;
              r_dwell_cnt <= DWELL_LOAD;
              r_ret_char  <= 1'b0;
            end else begin
              r_state    <= ST_IDLE;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end
          end
        end
        ST_DWELL: begin
          if (r_dwell_cnt == '0) begin
            if (r_ret_char) begin
              r_state      <= ST_CHAR;
              r_cell_valid <= 1'b1;
              r_cell_data  <= w_char_cell;
              r_is_prefix  <= 1'b0;
            end else begin
              r_state    <= ST_IDLE;
              r_in_ready <= 1'b1;
              r_busy     <= 1'b0;
            end
          end else begin
            r_dwell_cnt <= r_dwell_cnt - CW'(1);
          end
        end
        ST_ERR: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready       = r_in_ready;
  assign bus.cell_valid     = r_cell_valid;
  assign bus.cell_data      = r_cell_data;
  assign bus.cell_is_prefix = r_is_prefix;
  assign bus.busy           = r_busy;
  assign bus.err_pulse      = r_err_pulse;
  assign bus.err_count      = r_err_count;
  assign bus.dbg_state      = r_state;

endmodule
